div_unit: RTL and testbench
===========================

# div_unit

Iterative radix-2 divider/remainder unit for the RV32M execute stage, consuming the divide controls issued by the main decoder (`start_div_D`, `div_func_D`) after they are pipelined into execute. It is a 32-iteration restoring divider with a start/busy/done handshake. Divide-by-zero and signed overflow complete on a single-cycle fast path. Hazard logic stalls the pipeline on `busy`, and the `ALUResultSrc` mux selects `result` on `done`.

## Interface
- XLEN, 32, operand/result width
- FUNC_WIDTH, 2, width of `div_func`
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request; sampled only in IDLE or DONE
- div_func  input  FUNC_WIDTH  00 div, 01 divu, 10 rem, 11 remu; latched with `start`
- dividend  input  XLEN  rs1 value; latched with `start`
- divisor  input  XLEN  rs2 value; latched with `start`
- flush  input  1  synchronous abort of an in-flight op
- busy  output  1  high in CALC and FIX
- done  output  1  one-cycle pulse; `result` valid while high
- result  output  XLEN  registered quotient or remainder; holds until next completion

## Operation
- States: IDLE, CALC, FIX, DONE.
- Reset: state IDLE; busy=0, done=0, result=0; counter, remainder and quotient registers are 0.
- IDLE/DONE with start=1: latch func, dividend and divisor.
  - Special case → DONE directly, result written this edge.
  - Otherwise → CALC, counter=XLEN-1.
- IDLE/DONE with start=0: go to (or stay in) IDLE.
- Special cases, all per RISC-V M:
  - divisor==0: div/divu result 0xFFFFFFFF; rem/remu result = dividend.
  - Signed overflow, div/rem only, dividend 0x80000000 and divisor 0xFFFFFFFF: div result 0x80000000; rem result 0.
- Operand prep for normal ops:
  - div/rem: take absolute values of both operands. |0x80000000| = 0x80000000, treated as unsigned.
  - divu/remu: use raw operands.
  - Record neg_q = sign(dividend)^sign(divisor) and neg_r = sign(dividend), signed ops only.
- CALC, one iteration per cycle:
  - Shift the XLEN+1-bit partial remainder left, bringing in the next quotient-source MSB.
  - Trial-subtract the divisor.
  - If the result is non-negative, keep it and shift in quotient bit 1; else restore and shift in 0.
  - When counter==0, go to FIX; else decrement the counter.
- FIX:
  - Negate the quotient if neg_q; negate the remainder if neg_r.
  - Write quotient (div/divu) or remainder (rem/remu) to `result`.
  - → DONE.
- DONE: done=1 for exactly one cycle, then → IDLE unless a new start is accepted.
- start while busy: ignored, not queued.
- flush, priority over everything except rst:
  - In any state, next state is IDLE and done=0.
  - `result` is not updated; the in-flight op is dropped.
  - A start sampled in the same cycle as flush is dropped.
- rst mid-operation: immediate return to reset values regardless of clk.
- Quotient and remainder are truncated to XLEN; no exception or flag outputs.

## Timing
- Normal op, start sampled at edge 0:
  - CALC iterations on edges 1..32.
  - FIX on edge 33.
  - done=1 in the cycle after edge 33 (latency 34 cycles); busy=1 in the cycles following edges 0..32.
- Fast path: start at edge 0 → done=1 in the cycle after edge 0 (latency 1); busy stays 0.
- Back-to-back: start asserted during the DONE cycle is accepted at that edge; there are no idle bubbles.
- busy and done are never high in the same cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.
- flush at edge k → busy=0 and done=0 in the cycle after edge k.

## Test plan
- div 20 ÷ 0xFFFFFFFD (−3) → result 0xFFFFFFFA at done, 34 cycles after start. rem on the same operands → 0x00000002.
- divu 0xFFFFFFFF ÷ 2 → 0x7FFFFFFF. remu on the same operands → 1. rem 0xFFFFFFF9 (−7) ÷ 2 → 0xFFFFFFFF.
- div 7 ÷ 0 → 0xFFFFFFFF; rem 7 ÷ 0 → 7. Both give done one cycle after start, with busy never asserted.
- div 0x80000000 ÷ 0xFFFFFFFF → 0x80000000; rem on the same operands → 0. Both take the 1-cycle fast path.
- After a completed op with result=5, start div 100 ÷ 7, then flush 10 cycles later:
  - busy drops the next cycle, done never pulses, and result stays 5.
  - A new start for divu 100 ÷ 7 then yields 14.
- rst pulsed mid-CALC, asynchronous between edges → busy, done and result go to 0 immediately. The next start completes normally.

Source files
------------

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider/remainder for RV32M execute.
// 32 iterations per op; divide-by-zero and signed overflow finish in one cycle.
module div_unit #(
    parameter int XLEN       = 32,
    parameter int FUNC_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [FUNC_WIDTH-1:0] div_func,
    input  logic [XLEN-1:0]       dividend,
    input  logic [XLEN-1:0]       divisor,
    input  logic                  flush,
    output logic                  busy,
    output logic                  done,
    output logic [XLEN-1:0]       result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN:0]   rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN-1:0] result_q;
    logic            is_rem_q;
    logic            neg_q_q;
    logic            neg_r_q;
    logic            busy_q;
    logic            done_q;

    logic            is_signed;
    logic            is_rem;
    logic            div_zero;
    logic            ovf;
    logic            accept;
    logic [XLEN-1:0] spec_res;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   diff;
    logic [XLEN:0]   rem_d;
    logic [XLEN-1:0] quo_d;
    logic [XLEN-1:0] fix_q;
    logic [XLEN-1:0] fix_r;
    logic [XLEN-1:0] fix_res;

    always_comb begin
        is_signed = ~div_func[0];
        is_rem    = div_func[1];
        div_zero  = (divisor == '0);
        ovf       = is_signed && (dividend == MIN_NEG) && (divisor == '1);
        accept    = start && ((state_q == S_IDLE) || (state_q == S_DONE));

        spec_res = '0;
        if (div_zero) begin
            spec_res = is_rem ? dividend : '1;
        end else if (ovf) begin
            spec_res = is_rem ? '0 : MIN_NEG;
        end

        // |MIN_NEG| wraps back to MIN_NEG, which is correct as an unsigned magnitude
        abs_a = (is_signed && dividend[XLEN-1]) ? -dividend : dividend;
        abs_b = (is_signed && divisor[XLEN-1])  ? -divisor  : divisor;

        rem_sh = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
        diff   = rem_sh - {1'b0, dvs_q};
        if (!diff[XLEN]) begin
            rem_d = diff;
            quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            rem_d = rem_sh;
            quo_d = {quo_q[XLEN-2:0], 1'b0};
        end

        fix_q   = neg_q_q ? -quo_q : quo_q;
        fix_r   = neg_r_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
        fix_res = is_rem_q ? fix_r : fix_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            result_q <= '0;
            is_rem_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (flush) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        is_rem_q <= is_rem;
                        quo_q    <= abs_a;
                        dvs_q    <= abs_b;
                        rem_q    <= '0;
                        neg_q_q  <= is_signed & (dividend[XLEN-1] ^ divisor[XLEN-1]);
                        neg_r_q  <= is_signed & dividend[XLEN-1];
                        if (div_zero || ovf) begin
                            result_q <= spec_res;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            cnt_q   <= CW'(XLEN - 1);
                            busy_q  <= 1'b1;
                            state_q <= S_CALC;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    if (cnt_q == '0) begin
                        state_q <= S_FIX;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_FIX: begin
                    result_q <= fix_res;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= S_DONE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed and random checks for div_unit: latency, special cases,
// back-to-back issue, flush and asynchronous reset.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  div_func;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks   = 0;
    int failures = 0;
    int both_cnt = 0;
    logic [31:0] exp_q[$];

    div_unit #(.XLEN(32), .FUNC_WIDTH(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .div_func(div_func),
        .dividend(dividend),
        .divisor (divisor),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (busy && done) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [1:0] f,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 0) return f[1] ? a : 32'hFFFF_FFFF;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return f[1] ? 32'h0 : 32'h8000_0000;
        case (f)
            2'b00:   return 32'(sa / sb);
            2'b01:   return a / b;
            2'b10:   return 32'(sa % sb);
            default: return a % b;
        endcase
    endfunction

    task automatic wait_done(output int cyc, output bit bseen, output bit bgap);
        cyc   = 1;
        bseen = 0;
        bgap  = 0;
        while (!done && cyc < 200) begin
            if (busy) bseen = 1;
            else bgap = 1;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] f,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expv, input int lat);
        int cyc;
        bit bseen;
        bit bgap;
        logic [31:0] e;
        @(negedge clk);
        start    = 1'b1;
        div_func = f;
        dividend = a;
        divisor  = b;
        exp_q.push_back(expv);
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, bseen, bgap);
        chk({tag, "_done"}, 32'(done), 32'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        chk({tag, "_result"}, result, e);
        chk({tag, "_latency"}, cyc, lat);
        chk({tag, "_busy_seen"}, 32'(bseen), 32'(lat > 1));
        if (lat > 1) chk({tag, "_busy_gap"}, 32'(bgap), 32'd0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int cyc;
        bit bseen;
        bit bgap;
        bit dseen;
        logic [31:0] e;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [1:0]  rf;

        rst      = 1'b1;
        start    = 1'b0;
        div_func = 2'b00;
        dividend = '0;
        divisor  = '0;
        flush    = 1'b0;
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("div_neg3", 2'b00, 32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 34);
        run_op("rem_neg3", 2'b10, 32'd20, 32'hFFFF_FFFD, 32'h0000_0002, 34);
        run_op("divu_max", 2'b01, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 34);
        run_op("remu_max", 2'b11, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 34);
        run_op("rem_neg7", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        run_op("div_zero", 2'b00, 32'd7, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("rem_zero", 2'b10, 32'd7, 32'd0, 32'd7, 1);
        run_op("divu_zero", 2'b01, 32'd9, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
        run_op("divu_min", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 34);

        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 28);
            rf = 2'($urandom_range(0, 3));
            run_op("rand", rf, ra, rb, ref_div(rf, ra, rb),
                   (rb == 0 || (!rf[0] && ra == 32'h8000_0000 && rb == '1)) ? 1 : 34);
        end

        // Back-to-back: second start issued during the DONE cycle
        @(negedge clk);
        start    = 1'b1;
        div_func = 2'b01;
        dividend = 32'd50;
        divisor  = 32'd7;
        exp_q.push_back(32'd7);
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, bseen, bgap);
        chk("b2b_first_lat", cyc, 34);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        chk("b2b_first_result", result, e);
        start    = 1'b1;
        div_func = 2'b11;
        exp_q.push_back(32'd1);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", 32'(busy), 32'd1);
        wait_done(cyc, bseen, bgap);
        chk("b2b_second_lat", cyc, 34);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        chk("b2b_second_result", result, e);
        @(negedge clk);

        // Flush mid-CALC must drop the op and leave result untouched
        run_op("pre_flush", 2'b01, 32'd35, 32'd7, 32'd5, 34);
        start    = 1'b1;
        div_func = 2'b00;
        dividend = 32'd100;
        divisor  = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_done", 32'(done), 32'd0);
        dseen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) dseen = 1;
        end
        chk("flush_no_done", 32'(dseen), 32'd0);
        chk("flush_result_hold", result, 32'd5);
        run_op("post_flush", 2'b01, 32'd100, 32'd7, 32'd14, 34);

        // Asynchronous reset between clock edges during CALC
        start    = 1'b1;
        div_func = 2'b00;
        dividend = 32'd1000;
        divisor  = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_result", result, 32'd0);
        #1 rst = 1'b0;
        run_op("post_rst", 2'b00, 32'd1000, 32'd3, 32'd333, 34);

        chk("busy_done_excl", both_cnt, 32'd0);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
